// File: rtl/ofs_plat_avalon_mem_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM memory port among NUM_SRC engines.
// Write bursts are held atomic; a routing FIFO steers read responses to the issuing source.
module ofs_plat_avalon_mem_rr_arbiter #(
  parameter int unsigned NUM_SRC         = 4,
  parameter int unsigned ADDR_WIDTH      = 42,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned BURST_CNT_WIDTH = 7,
  parameter int unsigned RD_FIFO_DEPTH   = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0]          src_address,
  input  logic [NUM_SRC-1:0]                     src_read,
  input  logic [NUM_SRC-1:0]                     src_write,
  input  logic [NUM_SRC*BURST_CNT_WIDTH-1:0]     src_burstcount,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]          src_writedata,
  input  logic [NUM_SRC*(DATA_WIDTH/8)-1:0]      src_byteenable,
  output logic [NUM_SRC-1:0]                     src_waitrequest,
  output logic [DATA_WIDTH-1:0]                  src_readdata,
  output logic [NUM_SRC-1:0]                     src_readdatavalid,
  output logic [ADDR_WIDTH-1:0]                  mem_address,
  output logic                                   mem_read,
  output logic                                   mem_write,
  output logic [BURST_CNT_WIDTH-1:0]             mem_burstcount,
  output logic [DATA_WIDTH-1:0]                  mem_writedata,
  output logic [DATA_WIDTH/8-1:0]                mem_byteenable,
  input  logic                                   mem_waitrequest,
  input  logic [DATA_WIDTH-1:0]                  mem_readdata,
  input  logic                                   mem_readdatavalid,
  output logic                                   err_rsp_no_req
);
  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned PTR_W = $clog2(RD_FIFO_DEPTH);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  typedef enum logic {ARB, WR_LOCK} state_t;

  state_t                     state;
  logic [SRC_W-1:0]           rr_ptr, locked_src, arb_src, gnt_src, head_src;
  logic [SRC_W:0]             scan_idx;
  logic                       arb_found, gnt_valid, sel_read, sel_write, accept, push, pop;
  logic [NUM_SRC-1:0]         eligible;
  logic [BURST_CNT_WIDTH-1:0] beats_left, rsp_left, rsp_remaining, head_len;
  logic [SRC_W-1:0]           fifo_src [RD_FIFO_DEPTH];
  logic [BURST_CNT_WIDTH-1:0] fifo_len [RD_FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic [PTR_W:0]             count;
  logic                       fifo_full, fifo_empty, rsp_valid;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PTR_W+1)'(RD_FIFO_DEPTH));
  assign eligible   = src_write | (src_read & {NUM_SRC{~fifo_full}});

  // First eligible source at or after rr_ptr, wrapping modulo NUM_SRC
  always_comb begin
    arb_found = 1'b0;
    arb_src   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_idx = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (scan_idx >= (SRC_W+1)'(NUM_SRC)) scan_idx = scan_idx - (SRC_W+1)'(NUM_SRC);
      if (!arb_found && eligible[scan_idx[SRC_W-1:0]]) begin
        arb_found = 1'b1;
        arb_src   = scan_idx[SRC_W-1:0];
      end
    end
  end

  assign gnt_valid = ~reset & ((state == ARB) ? arb_found : 1'b1);
  assign gnt_src   = (state == WR_LOCK) ? locked_src : arb_src;

  always_comb begin
    mem_address     = '0;
    mem_burstcount  = '0;
    mem_writedata   = '0;
    mem_byteenable  = '0;
    sel_read        = 1'b0;
    sel_write       = 1'b0;
    src_waitrequest = '1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_src == SRC_W'(i)) begin
        mem_address    = src_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_burstcount = src_burstcount[i*BURST_CNT_WIDTH +: BURST_CNT_WIDTH];
        mem_writedata  = src_writedata[i*DATA_WIDTH +: DATA_WIDTH];
        mem_byteenable = src_byteenable[i*BE_W +: BE_W];
        sel_read       = src_read[i];
        sel_write      = src_write[i];
        if (gnt_valid) src_waitrequest[i] = mem_waitrequest;
      end
    end
  end

  // Reads are never issued while a write burst owns the port
  assign mem_read  = gnt_valid & sel_read & (state == ARB);
  assign mem_write = gnt_valid & sel_write;
  assign accept    = (mem_read | mem_write) & ~mem_waitrequest;
  assign push      = accept & mem_read;

  assign head_src      = fifo_src[rd_ptr];
  assign head_len      = fifo_len[rd_ptr];
  assign rsp_valid     = ~reset & mem_readdatavalid & ~fifo_empty;
  assign rsp_remaining = (rsp_left == '0) ? head_len : rsp_left;
  assign pop           = rsp_valid & (rsp_remaining == BURST_CNT_WIDTH'(1));
  assign src_readdata  = mem_readdata;

  always_comb begin
    src_readdatavalid = '0;
    for (int i = 0; i < NUM_SRC; i++)
      src_readdatavalid[i] = rsp_valid & (head_src == SRC_W'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ARB;
      rr_ptr         <= '0;
      locked_src     <= '0;
      beats_left     <= '0;
      rsp_left       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      err_rsp_no_req <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (accept) begin
            rr_ptr <= (arb_src == SRC_W'(NUM_SRC-1)) ? '0 : arb_src + SRC_W'(1);
            if (mem_write && (mem_burstcount > BURST_CNT_WIDTH'(1))) begin
              locked_src <= arb_src;
              beats_left <= mem_burstcount - BURST_CNT_WIDTH'(1);
              state      <= WR_LOCK;
            end
          end
        end
        WR_LOCK: begin
          if (accept) begin
            beats_left <= beats_left - BURST_CNT_WIDTH'(1);
            if (beats_left == BURST_CNT_WIDTH'(1)) state <= ARB;
          end
        end
        default: state <= ARB;
      endcase

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase

      if (rsp_valid) rsp_left <= pop ? '0 : rsp_remaining - BURST_CNT_WIDTH'(1);
      if (mem_readdatavalid && fifo_empty) err_rsp_no_req <= 1'b1;
    end
  end

  // Routing FIFO payload: issuing source and expected response beat count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_src[wr_ptr] <= gnt_src;
      fifo_len[wr_ptr] <= mem_burstcount;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_proto
    a_rw_excl: assert property (@(posedge clk) disable iff (reset)
      !(src_read[i] && src_write[i]));
    a_burst_nz: assert property (@(posedge clk) disable iff (reset)
      (src_read[i] || src_write[i]) |-> (src_burstcount[i*BURST_CNT_WIDTH +: BURST_CNT_WIDTH] != '0));
  end

endmodule

// File: tb/tb_ofs_plat_avalon_mem_rr_arbiter.sv
// Scoreboard bench for the round-robin Avalon arbiter: expected grants and response
// routing are queued as stimulus is issued and checked as the port side sees them.
module tb_ofs_plat_avalon_mem_rr_arbiter;
  localparam int NS = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = 7;
  localparam int FD = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NS*AW-1:0]  src_address;
  logic [NS-1:0]     src_read, src_write;
  logic [NS*BW-1:0]  src_burstcount;
  logic [NS*DW-1:0]  src_writedata;
  logic [NS*DW/8-1:0] src_byteenable;
  logic [NS-1:0]     src_waitrequest;
  logic [DW-1:0]     src_readdata;
  logic [NS-1:0]     src_readdatavalid;
  logic [AW-1:0]     mem_address;
  logic              mem_read, mem_write;
  logic [BW-1:0]     mem_burstcount;
  logic [DW-1:0]     mem_writedata;
  logic [DW/8-1:0]   mem_byteenable;
  logic              mem_waitrequest;
  logic [DW-1:0]     mem_readdata;
  logic              mem_readdatavalid;
  logic              err_rsp_no_req;

  ofs_plat_avalon_mem_rr_arbiter #(
    .NUM_SRC(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW), .RD_FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset),
    .src_address(src_address), .src_read(src_read), .src_write(src_write),
    .src_burstcount(src_burstcount), .src_writedata(src_writedata),
    .src_byteenable(src_byteenable), .src_waitrequest(src_waitrequest),
    .src_readdata(src_readdata), .src_readdatavalid(src_readdatavalid),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_burstcount(mem_burstcount), .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
    .err_rsp_no_req(err_rsp_no_req)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; logic [AW-1:0] addr; int burst; } cmd_t;
  typedef struct { int src; bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; } beat_t;
  typedef struct { int src; bit last; } rsp_t;

  cmd_t  cq [NS][$];
  cmd_t  cur [NS];
  bit    act [NS];
  int    rem [NS];
  bit    acc_s [NS];
  beat_t exp_q[$];
  rsp_t  rsp_q[$];
  int    rd_pend[$];
  int    acc_cyc[$];
  int    last_cyc[$];
  int    cyc = 0, acc_cnt = 0;
  int    n_chk = 0, n_fail = 0;
  bit    rsp_en = 1'b0, inject = 1'b0, flush = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] ad(input int s, input int t);
    return {4'(s), 12'(t)};
  endfunction

  task automatic cmd(input int s, input bit wr, input logic [AW-1:0] a, input int b);
    cmd_t c;
    c.wr = wr; c.addr = a; c.burst = b;
    cq[s].push_back(c);
  endtask

  task automatic exp_rd(input int s, input logic [AW-1:0] a, input int b);
    beat_t e;
    e.src = s; e.wr = 1'b0; e.addr = a; e.data = '0;
    exp_q.push_back(e);
    for (int k = 0; k < b; k++) begin
      rsp_t r;
      r.src = s; r.last = (k == b - 1);
      rsp_q.push_back(r);
    end
  endtask

  task automatic exp_wr(input int s, input logic [AW-1:0] a, input int b);
    for (int k = 0; k < b; k++) begin
      beat_t e;
      e.src = s; e.wr = 1'b1; e.addr = a; e.data = {a, 16'(k)};
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || rsp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drained", 64'(exp_q.size() + rsp_q.size()), 0);
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_cnt < target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("acc_wait", 64'(acc_cnt), 64'(target));
  endtask

  // Source engines and memory responder, updated just after each rising edge
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NS; i++) begin
      if (flush) begin
        act[i] = 1'b0;
        cq[i].delete();
      end else if (acc_s[i]) begin
        if (cur[i].wr && rem[i] > 1) rem[i] = rem[i] - 1;
        else begin
          act[i] = 1'b0;
          void'(cq[i].pop_front());
        end
      end
      if (!act[i] && cq[i].size() > 0) begin
        cur[i] = cq[i][0];
        act[i] = 1'b1;
        rem[i] = cur[i].burst;
      end
      src_read[i]                  = act[i] && !cur[i].wr;
      src_write[i]                 = act[i] && cur[i].wr;
      src_address[i*AW +: AW]      = cur[i].addr;
      src_burstcount[i*BW +: BW]   = BW'(cur[i].burst);
      src_writedata[i*DW +: DW]    = {cur[i].addr, 16'(cur[i].burst - rem[i])};
      src_byteenable[i*4 +: 4]     = 4'hF;
    end
    if (flush) begin
      rd_pend.delete();
      flush = 1'b0;
    end
    mem_readdatavalid = 1'b0;
    if (inject) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = 32'hDEAD_0000;
      inject            = 1'b0;
    end else if (rsp_en && rd_pend.size() > 0) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = DW'($urandom);
      rd_pend[0]        = rd_pend[0] - 1;
      if (rd_pend[0] == 0) void'(rd_pend.pop_front());
    end
  end

  // Port-side monitor: compares accepted beats and routed responses to the scoreboard
  always @(negedge clk) begin
    int    g;
    beat_t e;
    rsp_t  r;
    cyc++;
    for (int i = 0; i < NS; i++)
      acc_s[i] = !reset && (src_read[i] || src_write[i]) && !src_waitrequest[i];
    if ((mem_read || mem_write) && !mem_waitrequest) begin
      acc_cnt++;
      acc_cyc.push_back(cyc);
      g = -1;
      for (int i = 0; i < NS; i++) if (!src_waitrequest[i]) g = i;
      if (mem_read) rd_pend.push_back(int'(mem_burstcount));
      if (exp_q.size() == 0) chk("unexpected_accept", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("grant_src", 64'(g), 64'(e.src));
        chk("cmd_is_write", 64'(mem_write), 64'(e.wr));
        chk("cmd_addr", 64'(mem_address), 64'(e.addr));
        if (e.wr) chk("wdata", 64'(mem_writedata), 64'(e.data));
      end
    end
    if (mem_readdatavalid) begin
      if (rsp_q.size() == 0) chk("rdv_no_req", 64'(src_readdatavalid), 0);
      else begin
        r = rsp_q.pop_front();
        chk("rdv_route", 64'(src_readdatavalid), 64'(1) << r.src);
        chk("rdata", 64'(src_readdata), 64'(mem_readdata));
        if (r.last) last_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    int base;
    reset = 1'b1; mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdatavalid = 1'b0;
    src_read = '0; src_write = '0; src_address = '0; src_burstcount = '0;
    src_writedata = '0; src_byteenable = '0;
    for (int i = 0; i < NS; i++) begin act[i] = 1'b0; rem[i] = 0; acc_s[i] = 1'b0; end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd", {mem_read, mem_write}, 0);
    chk("rst_wait", 64'(src_waitrequest), 64'hF);
    chk("rst_rdv", 64'(src_readdatavalid), 0);
    chk("rst_err", 64'(err_rsp_no_req), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_wait", 64'(src_waitrequest), 64'hF);
    chk("idle_cmd", {mem_read, mem_write}, 0);

    // Single 4-beat read from src0
    rsp_en = 1'b1;
    cmd(0, 1'b0, ad(0, 16'h10), 4); exp_rd(0, ad(0, 16'h10), 4);
    wait_drain(100);
    chk("single_err", 64'(err_rsp_no_req), 0);

    // Fairness: rr_ptr is 1 after src0 was served
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < NS; s++) cmd(s, 1'b0, ad(s, 16'h20 + r), 1);
    for (int r = 0; r < 2; r++)
      for (int k = 1; k <= NS; k++) exp_rd(k % NS, ad(k % NS, 16'h20 + r), 1);
    wait_drain(100);

    // Write atomicity: src1 8-beat write vs pending src2 read
    acc_cyc.delete();
    cmd(1, 1'b1, ad(1, 16'h30), 8); cmd(2, 1'b0, ad(2, 16'h31), 1);
    exp_wr(1, ad(1, 16'h30), 8);    exp_rd(2, ad(2, 16'h31), 1);
    wait_drain(100);
    chk("wr_contig", 64'(acc_cyc[7] - acc_cyc[0]), 7);
    chk("rd_after_burst", 64'(acc_cyc[8] - acc_cyc[7]), 1);

    // Back-pressure mid-burst
    base = acc_cnt;
    cmd(0, 1'b1, ad(0, 16'h40), 8); cmd(1, 1'b0, ad(1, 16'h41), 1);
    exp_wr(0, ad(0, 16'h40), 8);    exp_rd(1, ad(1, 16'h41), 1);
    wait_acc(base + 3);
    mem_waitrequest = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_wait", 64'(src_waitrequest), 64'hF);
      chk("stall_hold", {mem_write, mem_read, mem_address}, {2'b10, ad(0, 16'h40)});
    end
    chk("stall_noacc", 64'(acc_cnt), 64'(base + 3));
    @(posedge clk); #1 mem_waitrequest = 1'b0;
    wait_drain(100);

    // FIFO full: reads blocked, write still granted
    rsp_en = 1'b0;
    acc_cyc.delete(); last_cyc.delete();
    base = acc_cnt;
    @(negedge clk);
    cmd(2, 1'b0, ad(2, 16'h50), 2); cmd(2, 1'b0, ad(2, 16'h53), 1);
    cmd(0, 1'b0, ad(0, 16'h51), 1);
    cmd(1, 1'b0, ad(1, 16'h52), 1); cmd(1, 1'b0, ad(1, 16'h54), 1);
    exp_rd(2, ad(2, 16'h50), 2); exp_rd(0, ad(0, 16'h51), 1);
    exp_rd(1, ad(1, 16'h52), 1); exp_rd(2, ad(2, 16'h53), 1);
    wait_acc(base + 4);
    repeat (3) begin
      @(negedge clk);
      chk("full_block", 64'(src_waitrequest), 64'hF);
      chk("full_noread", 64'(mem_read), 0);
    end
    cmd(3, 1'b1, ad(3, 16'h55), 1);
    exp_wr(3, ad(3, 16'h55), 1); exp_rd(1, ad(1, 16'h54), 1);
    wait_acc(base + 5);
    rsp_en = 1'b1;
    wait_drain(100);
    chk("full_release", 64'(acc_cyc[5] - last_cyc[0]), 1);

    // Response with nothing outstanding
    @(negedge clk); #1 inject = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("err_set", 64'(err_rsp_no_req), 1);
    repeat (5) @(negedge clk);
    chk("err_sticky", 64'(err_rsp_no_req), 1);

    // Reset in the middle of a write burst
    base = acc_cnt;
    @(negedge clk);
    cmd(0, 1'b1, ad(0, 16'h60), 8); exp_wr(0, ad(0, 16'h60), 8);
    wait_acc(base + 3);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_write", 64'(mem_write), 0);
    chk("midrst_wait", 64'(src_waitrequest), 64'hF);
    chk("midrst_err", 64'(err_rsp_no_req), 0);
    flush = 1'b1;
    exp_q.delete(); rsp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd", {mem_read, mem_write}, 0);
    for (int s = 0; s < NS; s++) begin
      cmd(s, 1'b0, ad(s, 16'h70), 1);
      exp_rd(s, ad(s, 16'h70), 1);
    end
    wait_drain(100);
    chk("post_rst_err", 64'(err_rsp_no_req), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
